// File: rtl/inst_fetch_stage_pkg.sv
// rtl/inst_fetch_stage_pkg.sv - shared pipeline constants and IF/ID layout
package inst_fetch_stage_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0]  DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] DEF_NOP_INSTR = 32'h0000_0000;

    // IF/ID pipeline register layout, also consumed by decode
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc_plus4;
        logic               valid;
    } if_id_t;

    // Source of the next PC value
    typedef enum logic [1:0] {
        PC_SRC_SEQ   = 2'd0,
        PC_SRC_HOLD  = 2'd1,
        PC_SRC_REDIR = 2'd2
    } pc_src_e;

endpackage

// File: rtl/inst_fetch_stage_if.sv
// rtl/inst_fetch_stage_if.sv - instruction-memory bus between fetch and inst_memory
//   imem_addr  : byte address driven by the fetch stage
//   imem_rdata : instruction word returned combinationally by memory
interface inst_fetch_stage_if;
    import inst_fetch_stage_pkg::*;

    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (output imem_addr, input  imem_rdata);
    modport slave  (input  imem_addr, output imem_rdata);
endinterface

// File: rtl/inst_fetch_stage_pc_next_sel.sv
// rtl/inst_fetch_stage_pc_next_sel.sv - next-PC mux and redirect alignment check
//   pc_q        in  : current PC
//   stall       in  : hold request
//   redirect    in  : taken branch/jump
//   redirect_pc in  : redirect target (low bits dropped)
//   pc_plus4    out : pc_q + 4, modulo 2^32
//   pc_next     out : value to load into pc_q on a non-reset edge
//   pc_src      out : which source was chosen
//   misalign    out : redirect target bits [1:0] non-zero
module inst_fetch_stage_pc_next_sel
    import inst_fetch_stage_pkg::*;
(
    input  logic [ADDR_W-1:0] pc_q,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] pc_next,
    output pc_src_e           pc_src,
    output logic              misalign
);

    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        misalign = (redirect_pc[1:0] != 2'b00);

        // Redirect beats stall; flush does not affect the PC choice
        pc_src = PC_SRC_SEQ;
        if (redirect) begin
            pc_src = PC_SRC_REDIR;
        end else if (stall) begin
            pc_src = PC_SRC_HOLD;
        end

        case (pc_src)
            PC_SRC_REDIR: pc_next = {redirect_pc[ADDR_W-1:2], 2'b00};
            PC_SRC_HOLD:  pc_next = pc_q;
            default:      pc_next = pc_plus4;
        endcase
    end

endmodule

// File: rtl/inst_fetch_stage.sv
// rtl/inst_fetch_stage.sv - instruction fetch stage: PC, imem address, IF/ID register
//   clk, rst_n            : clock, synchronous active-low reset
//   stall, flush          : hazard controls from later stages
//   redirect, redirect_pc : taken branch/jump and its target
//   imem                  : instruction-memory bus (master side)
//   if_id_instr/pc_plus4/valid : IF/ID register to decode
//   fetch_count           : saturating count of captured instructions
//   misalign_err          : sticky misaligned redirect target flag
module inst_fetch_stage
    import inst_fetch_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC  = DEF_RESET_PC,
    parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR,
    parameter int                 CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                flush,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    inst_fetch_stage_if.master  imem,
    output logic [INSTR_W-1:0]  if_id_instr,
    output logic [ADDR_W-1:0]   if_id_pc_plus4,
    output logic                if_id_valid,
    output logic [CNT_W-1:0]    fetch_count,
    output logic                misalign_err
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] pc_next;
    pc_src_e           pc_src;
    logic              misalign;
    logic              advance;
    if_id_t            if_id_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;

    localparam if_id_t BUBBLE = '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};

    inst_fetch_stage_pc_next_sel u_pc_next_sel (
        .pc_q        (pc_q),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc_plus4    (pc_plus4),
        .pc_next     (pc_next),
        .pc_src      (pc_src),
        .misalign    (misalign)
    );

    // A flush without stall still steps the PC, but the word is discarded
    assign advance = (pc_src == PC_SRC_SEQ) && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            if_id_q <= BUBBLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            pc_q <= pc_next;
            if (redirect || flush) begin
                if_id_q <= BUBBLE;
            end else if (!stall) begin
                if_id_q <= '{instr: imem.imem_rdata, pc_plus4: pc_plus4, valid: 1'b1};
            end
            if (advance && !(&cnt_q)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (redirect && misalign) begin
                err_q <= 1'b1;
            end
        end
    end

    assign imem.imem_addr  = pc_q;
    assign if_id_instr     = if_id_q.instr;
    assign if_id_pc_plus4  = if_id_q.pc_plus4;
    assign if_id_valid     = if_id_q.valid;
    assign fetch_count     = cnt_q;
    assign misalign_err    = err_q;

endmodule

// File: tb/tb_inst_fetch_stage.sv
// tb/tb_inst_fetch_stage.sv - bench for inst_fetch_stage with program-image memory
module tb_inst_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic [31:0] if_id_instr, if_id_pc_plus4;
    logic        if_id_valid, misalign_err;
    logic [15:0] fetch_count;

    logic [31:0] s_instr, s_pc_plus4;
    logic        s_valid, s_err;
    logic [1:0]  s_count;

    logic [31:0] prog [64];

    int passed = 0;
    int total  = 0;

    // reference state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_err;
    logic [15:0] m_cnt;
    logic [1:0]  m_cnt2;

    always #5 clk = ~clk;

    inst_fetch_stage_if bus ();
    inst_fetch_stage_if bus_sat ();

    assign bus.imem_rdata     = prog[bus.imem_addr[7:2]];
    assign bus_sat.imem_rdata = prog[bus_sat.imem_addr[7:2]];

    inst_fetch_stage #(.CNT_W(16)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem           (bus),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .fetch_count    (fetch_count),
        .misalign_err   (misalign_err)
    );

    inst_fetch_stage #(.CNT_W(2)) u_sat (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem           (bus_sat),
        .if_id_instr    (s_instr),
        .if_id_pc_plus4 (s_pc_plus4),
        .if_id_valid    (s_valid),
        .fetch_count    (s_count),
        .misalign_err   (s_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Behaviour of one clock edge written straight from the stage rules
    task automatic model_edge();
        logic [31:0] word;
        word = prog[m_pc[7:2]];
        if (!rst_n) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            m_cnt = 16'h0; m_cnt2 = 2'h0; m_err = 1'b0;
        end else if (redirect) begin
            if (redirect_pc % 4 != 0) m_err = 1'b1;
            m_pc = redirect_pc - (redirect_pc % 4);
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (flush) begin
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            if (!stall) m_pc = m_pc + 32'd4;
        end else if (!stall) begin
            m_instr = word;
            m_pc4 = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".addr"},     bus.imem_addr,        m_pc);
        chk({tag, ".instr"},    if_id_instr,          m_instr);
        chk({tag, ".pc4"},      if_id_pc_plus4,       m_pc4);
        chk({tag, ".valid"},    {31'h0, if_id_valid}, {31'h0, m_valid});
        chk({tag, ".count"},    {16'h0, fetch_count}, {16'h0, m_cnt});
        chk({tag, ".err"},      {31'h0, misalign_err}, {31'h0, m_err});
        chk({tag, ".satcount"}, {30'h0, s_count},     {30'h0, m_cnt2});
        chk({tag, ".sataddr"},  bus_sat.imem_addr,    m_pc);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) prog[i] = $urandom;
        prog[0] = 32'h00A60820;
        prog[1] = 32'h02852822;
        prog[2] = 32'h02384826;
        prog[3] = 32'h3A6D0004;
        prog[5] = 32'h3C140001;

        // reset, with other controls asserted to show reset dominance
        #2;
        rst_n = 1'b0; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h33;
        step("reset");
        chk("reset.addr_lit", bus.imem_addr, 32'h0);
        stall = 1'b0; redirect = 1'b0;

        // free run
        rst_n = 1'b1;
        step("run1");
        chk("run1.instr_lit", if_id_instr, 32'h00A60820);
        chk("run1.pc4_lit", if_id_pc_plus4, 32'd4);
        step("run2");
        chk("run2.instr_lit", if_id_instr, 32'h02852822);
        chk("run2.addr_lit", bus.imem_addr, 32'd8);

        // stall two cycles at pc 8
        stall = 1'b1;
        step("stall1");
        step("stall2");
        chk("stall2.instr_lit", if_id_instr, 32'h02852822);
        chk("stall2.count_lit", {16'h0, fetch_count}, 32'd2);
        stall = 1'b0;
        step("release");
        chk("release.instr_lit", if_id_instr, 32'h02384826);
        chk("release.satcount_lit", {30'h0, s_count}, 32'd3);
        step("run4");
        chk("run4.instr_lit", if_id_instr, 32'h3A6D0004);
        chk("run4.pc4_lit", if_id_pc_plus4, 32'd16);
        chk("run4.satcount_lit", {30'h0, s_count}, 32'd3);

        // redirect to 20
        redirect = 1'b1; redirect_pc = 32'd20;
        step("redir");
        chk("redir.addr_lit", bus.imem_addr, 32'd20);
        chk("redir.valid_lit", {31'h0, if_id_valid}, 32'd0);
        redirect = 1'b0;
        step("redir_next");
        chk("redir_next.instr_lit", if_id_instr, 32'h3C140001);
        chk("redir_next.pc4_lit", if_id_pc_plus4, 32'd24);

        // redirect + stall + flush, misaligned target
        redirect = 1'b1; stall = 1'b1; flush = 1'b1; redirect_pc = 32'h13;
        step("combo");
        chk("combo.addr_lit", bus.imem_addr, 32'h10);
        chk("combo.err_lit", {31'h0, misalign_err}, 32'd1);
        redirect = 1'b0; stall = 1'b0;
        step("flush_only");
        flush = 1'b0;
        step("sticky1");
        flush = 1'b1; stall = 1'b1;
        step("flush_stall");
        flush = 1'b0; stall = 1'b0;
        step("sticky2");

        // reset mid-stall and mid-redirect
        stall = 1'b1;
        step("pre_rst");
        rst_n = 1'b0; redirect = 1'b1; redirect_pc = 32'h44;
        step("mid_rst");
        chk("mid_rst.err_lit", {31'h0, misalign_err}, 32'd0);
        rst_n = 1'b1; stall = 1'b0;

        // PC wrap
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step("wrap_set");
        redirect = 1'b0;
        step("wrap");
        chk("wrap.addr_lit", bus.imem_addr, 32'h0);
        chk("wrap.pc4_lit", if_id_pc_plus4, 32'h0);
        chk("wrap.instr_lit", if_id_instr, prog[63]);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            rst_n       = ($urandom_range(0, 59) != 0);
            stall       = ($urandom_range(0, 3) == 0);
            flush       = ($urandom_range(0, 5) == 0);
            redirect    = ($urandom_range(0, 6) == 0);
            redirect_pc = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                                                      : 32'($urandom_range(0, 255));
            step("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
